// File: rtl/sca_blk_alloc.sv
// rtl/sca_blk_alloc.sv - block allocation map with next-free-block lookup
//
// Purpose:
//   Tracks which of 16 blocks are busy and offers the lowest free block
//   that is not the block currently being written. The map can optionally
//   be triplicated with a bitwise 2-of-3 vote and scrubbed every cycle.
//
// Parameters:
//   TMR  - 1: three map copies with majority vote, 0: single copy
//   SIM  - reserved for simulation-only options, no functional effect
//
// Ports:
//   clk_i         - clock, all state on rising edge
//   rst_ni        - asynchronous active-low reset, clears the map
//   wrena_i       - map-update enable
//   nbsel_i       - block-map select (update needs wrena_i and nbsel_i)
//   sela_i        - 1: mark badr_i busy, 0: mark badr_i free
//   badr_i        - block address to update
//   rdadr_i       - block being written, never offered as next block
//   nadr_o        - next free block address (rdadr_i when none)
//   bmem_o        - block map, bit i = 1 means block i busy
//   nfree_blks_o  - number of free blocks, saturated at 15
//   scafull_o     - no free block other than rdadr_i
module sca_blk_alloc #(
  parameter int TMR = 0,
  parameter int SIM = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wrena_i,
  input  logic        nbsel_i,
  input  logic        sela_i,
  input  logic [3:0]  badr_i,
  input  logic [3:0]  rdadr_i,
  output logic [3:0]  nadr_o,
  output logic [15:0] bmem_o,
  output logic [3:0]  nfree_blks_o,
  output logic        scafull_o
);

  logic [15:0] map_v;   // voted (or single) map value seen by all outputs
  logic [15:0] map_d;   // next-state map, shared by every copy
  logic [15:0] avail;   // free blocks excluding rdadr_i
  logic [4:0]  free_cnt;

  // The next state is always derived from the voted value, so in TMR mode
  // every copy reloads the majority each cycle and a single upset is gone
  // after one edge.
  always_comb begin
    map_d = map_v;
    if (wrena_i && nbsel_i) begin
      map_d[badr_i] = sela_i;
    end
  end

  if (TMR != 0) begin : g_tmr
    logic [15:0] copy0_q, copy1_q, copy2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        copy0_q <= 16'h0000;
        copy1_q <= 16'h0000;
        copy2_q <= 16'h0000;
      end else begin
        copy0_q <= map_d;
        copy1_q <= map_d;
        copy2_q <= map_d;
      end
    end

    assign map_v = (copy0_q & copy1_q) | (copy0_q & copy2_q) | (copy1_q & copy2_q);
  end else begin : g_single
    logic [15:0] map_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        map_q <= 16'h0000;
      end else begin
        map_q <= map_d;
      end
    end

    assign map_v = map_q;
  end

  if (SIM != 0) begin : g_sim
  end

  assign bmem_o = map_v;

  // Priority encoder: scan from the top so the lowest free index wins.
  always_comb begin
    avail          = ~map_v;
    avail[rdadr_i] = 1'b0;
    nadr_o         = rdadr_i;
    for (int i = 15; i >= 0; i--) begin
      if (avail[i]) begin
        nadr_o = 4'(i);
      end
    end
  end

  assign scafull_o = ~|avail;

  // Popcount of free blocks; 16 does not fit in 4 bits so it saturates.
  always_comb begin
    free_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      free_cnt = free_cnt + {4'd0, ~map_v[i]};
    end
  end

  assign nfree_blks_o = free_cnt[4] ? 4'd15 : free_cnt[3:0];

endmodule

// File: tb/tb_sca_blk_alloc.sv
// tb/tb_sca_blk_alloc.sv - scoreboard bench for sca_blk_alloc (single and TMR)
module tb_sca_blk_alloc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrena = 1'b0;
  logic        nbsel = 1'b0;
  logic        sela = 1'b0;
  logic [3:0]  badr = 4'd0;
  logic [3:0]  rdadr = 4'd0;

  logic [3:0]  nadr_s, nadr_t;
  logic [15:0] bmem_s, bmem_t;
  logic [3:0]  nfree_s, nfree_t;
  logic        full_s, full_t;

  sca_blk_alloc #(.TMR(0), .SIM(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .wrena_i(wrena), .nbsel_i(nbsel),
    .sela_i(sela), .badr_i(badr), .rdadr_i(rdadr),
    .nadr_o(nadr_s), .bmem_o(bmem_s), .nfree_blks_o(nfree_s), .scafull_o(full_s)
  );

  sca_blk_alloc #(.TMR(1), .SIM(0)) u_tmr (
    .clk_i(clk), .rst_ni(rst_n), .wrena_i(wrena), .nbsel_i(nbsel),
    .sela_i(sela), .badr_i(badr), .rdadr_i(rdadr),
    .nadr_o(nadr_t), .bmem_o(bmem_t), .nfree_blks_o(nfree_t), .scafull_o(full_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bmem;
    logic [3:0]  nadr;
    logic [3:0]  nfree;
    logic        full;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model = 16'h0000;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [15:0] m, input logic [3:0] rd);
    exp_t e;
    int   nf;
    logic found;
    nf      = $countones(~m);
    e.bmem  = m;
    e.nfree = (nf > 15) ? 4'd15 : 4'(nf);
    e.nadr  = rd;
    e.full  = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && !m[i] && (i != int'(rd))) begin
        e.nadr = 4'(i);
        e.full = 1'b0;
        found  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd0, 16'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_bmem"},  bmem_s,          e.bmem);
    check({tag, "_nadr"},  {12'd0, nadr_s},  {12'd0, e.nadr});
    check({tag, "_nfree"}, {12'd0, nfree_s}, {12'd0, e.nfree});
    check({tag, "_full"},  {15'd0, full_s},  {15'd0, e.full});
    check({tag, "_tbmem"},  bmem_t,          e.bmem);
    check({tag, "_tnadr"},  {12'd0, nadr_t},  {12'd0, e.nadr});
    check({tag, "_tnfree"}, {12'd0, nfree_t}, {12'd0, e.nfree});
    check({tag, "_tfull"},  {15'd0, full_t},  {15'd0, e.full});
  endtask

  task automatic step(input string tag, input logic wr, input logic nb,
                      input logic sa, input logic [3:0] ba, input logic [3:0] rd);
    @(negedge clk);
    wrena = wr; nbsel = nb; sela = sa; badr = ba; rdadr = rd;
    if (rst_n && wr && nb) model[ba] = sa;
    sb.push_back(predict(model, rd));
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic set_rd(input string tag, input logic [3:0] rd);
    @(negedge clk);
    wrena = 1'b0; nbsel = 1'b0; rdadr = rd;
    #1;
    sb.push_back(predict(model, rd));
    compare_out(tag);
  endtask

  initial begin
    #250000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, sampled between edges
    #12;
    check("rst_bmem",  bmem_s, 16'h0000);
    check("rst_nadr",  {12'd0, nadr_s}, 16'd1);
    check("rst_nfree", {12'd0, nfree_s}, 16'd15);
    check("rst_full",  {15'd0, full_s}, 16'd0);
    check("rst_tnadr", {12'd0, nadr_t}, 16'd1);
    rdadr = 4'd3;
    #1;
    check("rst_nadr_rd3", {12'd0, nadr_s}, 16'd0);

    // updates while in reset are ignored
    step("rst_upd", 1'b1, 1'b1, 1'b1, 4'd2, 4'd0);
    check("rst_upd_const", bmem_s, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1; wrena = 1'b0; nbsel = 1'b0;

    // TMR scrub: upset one copy while the map is all free
    force u_tmr.g_tmr.copy1_q = 16'h0020;
    #1;
    check("tmr_vote", bmem_t, 16'h0000);
    check("tmr_vote_nfree", {12'd0, nfree_t}, 16'd15);
    release u_tmr.g_tmr.copy1_q;
    @(posedge clk);
    #1;
    check("tmr_scrub", u_tmr.g_tmr.copy1_q, 16'h0000);

    // allocate 1,2,3
    for (int b = 1; b <= 3; b++) step("alloc123", 1'b1, 1'b1, 1'b1, 4'(b), 4'd0);
    check("a123_bmem",  bmem_s, 16'h000E);
    check("a123_nadr",  {12'd0, nadr_s}, 16'd4);
    check("a123_nfree", {12'd0, nfree_s}, 16'd13);

    // allocate the rest (3 again is idempotent)
    for (int b = 3; b <= 15; b++) step("alloc_all", 1'b1, 1'b1, 1'b1, 4'(b), 4'd0);
    check("full_bmem",  bmem_s, 16'hFFFE);
    check("full_flag",  {15'd0, full_s}, 16'd1);
    check("full_nadr",  {12'd0, nadr_s}, 16'd0);
    check("full_nfree", {12'd0, nfree_s}, 16'd1);

    step("rel9", 1'b1, 1'b1, 1'b0, 4'd9, 4'd0);
    check("rel9_bmem",  bmem_s, 16'hFDFE);
    check("rel9_nadr",  {12'd0, nadr_s}, 16'd9);
    check("rel9_full",  {15'd0, full_s}, 16'd0);
    check("rel9_nfree", {12'd0, nfree_s}, 16'd2);

    // partial enables do nothing; repeated release is idempotent
    step("no_nbsel", 1'b1, 1'b0, 1'b1, 4'd9, 4'd0);
    step("no_wrena", 1'b0, 1'b1, 1'b1, 4'd9, 4'd0);
    check("noupd_bmem", bmem_s, 16'hFDFE);
    step("rel9_again", 1'b1, 1'b1, 1'b0, 4'd9, 4'd0);

    // rdadr acts combinationally
    set_rd("rd9", 4'd9);
    check("rd9_nadr", {12'd0, nadr_s}, 16'd0);
    step("alloc0_rd9", 1'b1, 1'b1, 1'b1, 4'd0, 4'd9);
    check("rd9_full", {15'd0, full_s}, 16'd1);
    set_rd("rd5", 4'd5);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // asynchronous reset between edges
    step("pre_arst", 1'b1, 1'b1, 1'b1, 4'd7, 4'd0);
    @(negedge clk);
    wrena = 1'b0; nbsel = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model = 16'h0000;
    check("arst_bmem",  bmem_s, 16'h0000);
    check("arst_tbmem", bmem_t, 16'h0000);
    check("arst_nfree", {12'd0, nfree_s}, 16'd15);

    // first edge after release accepts an update
    @(negedge clk);
    rst_n = 1'b1;
    step("post_arst", 1'b1, 1'b1, 1'b1, 4'd0, 4'd5);
    check("post_arst_bmem", bmem_s, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
